// File: rtl/enc_frame_packer_if.sv
// Symbol-in / frame-out handshake bundle of the encoder-to-decoder frame packer.
interface enc_frame_packer_if #(
  parameter int MAX_CODE_RATE = 3,
  parameter int FRAME_SYMS    = 8,
  parameter int FRAME_W       = MAX_CODE_RATE * FRAME_SYMS
);
  logic [MAX_CODE_RATE-1:0] i_sym;
  logic                     i_sym_valid;
  logic                     o_sym_ready;
  logic                     i_flush;
  logic [FRAME_W-1:0]       o_frame;
  logic [3:0]               o_frame_len;
  logic [1:0]               o_frame_rate;
  logic                     o_frame_valid;
  logic                     i_frame_ready;
  logic                     o_overflow;

  modport master (
    output i_sym, i_sym_valid, i_flush, i_frame_ready,
    input  o_sym_ready, o_frame, o_frame_len, o_frame_rate, o_frame_valid, o_overflow
  );

  modport slave (
    input  i_sym, i_sym_valid, i_flush, i_frame_ready,
    output o_sym_ready, o_frame, o_frame_len, o_frame_rate, o_frame_valid, o_overflow
  );
endinterface

// File: rtl/enc_frame_packer.sv
// Packs code symbols LSB-first into frames held in a two-entry ping-pong buffer,
// presenting completed frames downstream over valid/ready.
module enc_frame_packer #(
  parameter int MAX_CODE_RATE = 3,
  parameter int FRAME_SYMS    = 8,
  parameter int FRAME_W       = MAX_CODE_RATE * FRAME_SYMS
) (
  input  logic               sys_clk,
  input  logic               rst,
  input  logic               en,
  input  logic [1:0]         i_code_rate,
  enc_frame_packer_if.slave  bus
);
  localparam int CNT_W = 4;
  localparam int SH_W  = $clog2(FRAME_W) + 1;

  logic [FRAME_W-1:0] buf_data [2];
  logic [CNT_W-1:0]   buf_len  [2];
  logic [1:0]         buf_rate [2];
  logic               wp;
  logic               rp;
  logic [1:0]         full_cnt;
  logic [CNT_W-1:0]   fill_cnt;
  logic               overflow;

  logic               sym_ready;
  logic               frame_valid;
  logic               take;
  logic               complete;
  logic               flush_take;
  logic               close;
  logic               xfer;
  logic [1:0]         cur_rate;
  logic [SH_W-1:0]    shamt;
  logic [FRAME_W-1:0] sym_word;
  logic [CNT_W-1:0]   fill_nxt;

  function automatic logic [1:0] dec_rate(input logic [1:0] r);
    return (r == 2'd3) ? 2'd3 : 2'd2;
  endfunction

  function automatic logic [MAX_CODE_RATE-1:0] mask_sym(input logic [1:0] r,
                                                        input logic [MAX_CODE_RATE-1:0] s);
    logic [MAX_CODE_RATE-1:0] m;
    for (int b = 0; b < MAX_CODE_RATE; b++) m[b] = (b < int'(r)) ? s[b] : 1'b0;
    return m;
  endfunction

  assign sym_ready   = (full_cnt != 2'd2);
  assign frame_valid = (full_cnt != 2'd0);

  always_comb begin
    take       = en & bus.i_sym_valid & sym_ready;
    // The rate is captured by the first symbol of a buffer and frozen for the rest of it.
    cur_rate   = (fill_cnt == '0) ? dec_rate(i_code_rate) : buf_rate[wp];
    shamt      = SH_W'(fill_cnt) * SH_W'(cur_rate);
    sym_word   = FRAME_W'(mask_sym(cur_rate, bus.i_sym)) << shamt;
    fill_nxt   = fill_cnt + CNT_W'(take);
    complete   = take & (fill_nxt == CNT_W'(FRAME_SYMS));
    flush_take = en & bus.i_flush & (fill_nxt != '0) & sym_ready;
    close      = complete | flush_take;
    xfer       = frame_valid & bus.i_frame_ready;
  end

  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        buf_data[i] <= '0;
        buf_len[i]  <= '0;
        buf_rate[i] <= 2'd2;
      end
      wp       <= 1'b0;
      rp       <= 1'b0;
      full_cnt <= 2'd0;
      fill_cnt <= '0;
      overflow <= 1'b0;
    end else begin
      // A buffer is only written while it is the fill side, so the first symbol
      // overwrites whatever an earlier, already delivered frame left behind.
      if (take) begin
        buf_data[wp] <= (fill_cnt == '0) ? sym_word : (buf_data[wp] | sym_word);
        if (fill_cnt == '0) buf_rate[wp] <= cur_rate;
      end
      if (close) begin
        buf_len[wp] <= fill_nxt;
        wp          <= ~wp;
        fill_cnt    <= '0;
      end else begin
        fill_cnt <= fill_nxt;
      end
      if (xfer) rp <= ~rp;
      full_cnt <= full_cnt + {1'b0, close} - {1'b0, xfer};
      if (en & bus.i_sym_valid & ~sym_ready) overflow <= 1'b1;
    end
  end

  assign bus.o_sym_ready   = sym_ready;
  assign bus.o_frame_valid = frame_valid;
  assign bus.o_frame       = buf_data[rp];
  assign bus.o_frame_len   = buf_len[rp];
  assign bus.o_frame_rate  = buf_rate[rp];
  assign bus.o_overflow    = overflow;
endmodule

// File: tb/tb_enc_frame_packer.sv
// Directed bench for enc_frame_packer: a frame-queue model checked every cycle,
// plus literal expectations for the hand-computed test vectors.
module tb_enc_frame_packer;
  localparam int FS = 8;

  logic       sys_clk = 1'b0;
  logic       rst     = 1'b0;
  logic       en      = 1'b0;
  logic [1:0] code_rate = 2'd2;

  enc_frame_packer_if bus ();

  enc_frame_packer dut (
    .sys_clk     (sys_clk),
    .rst         (rst),
    .en          (en),
    .i_code_rate (code_rate),
    .bus         (bus)
  );

  always #5 sys_clk = ~sys_clk;

  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  // Behavioural model: completed frames waiting downstream, plus the open frame.
  typedef struct {
    logic [23:0] data;
    int          len;
    int          rate;
  } frame_t;

  frame_t q[$];
  int     m_pcnt;
  int     m_prate;
  int     m_psym [FS];
  logic   m_ovf;

  always @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      q.delete();
      m_pcnt  = 0;
      m_prate = 2;
      m_ovf   = 1'b0;
    end else begin
      int pre;
      pre = q.size();
      if (en && bus.i_sym_valid && pre >= 2) m_ovf = 1'b1;
      if (en && bus.i_sym_valid && pre < 2) begin
        if (m_pcnt == 0) m_prate = (code_rate == 2'd3) ? 3 : 2;
        m_psym[m_pcnt] = int'(bus.i_sym);
        m_pcnt++;
      end
      if (m_pcnt == FS || (en && bus.i_flush && m_pcnt > 0 && pre < 2)) begin
        frame_t f;
        f.data = '0;
        for (int k = 0; k < m_pcnt; k++)
          f.data = f.data | 24'((m_psym[k] % (1 << m_prate)) << (k * m_prate));
        f.len  = m_pcnt;
        f.rate = m_prate;
        q.push_back(f);
        m_pcnt = 0;
      end
      if (pre > 0 && bus.i_frame_ready) void'(q.pop_front());
    end
  end

  always @(negedge sys_clk) begin
    if (!rst) begin
      check("rst_valid",     32'(bus.o_frame_valid), 32'd0);
      check("rst_sym_ready", 32'(bus.o_sym_ready),   32'd1);
      check("rst_frame",     32'(bus.o_frame),       32'd0);
      check("rst_rate",      32'(bus.o_frame_rate),  32'd2);
    end else begin
      check("valid",     32'(bus.o_frame_valid), 32'(q.size() != 0));
      check("sym_ready", 32'(bus.o_sym_ready),   32'(q.size() < 2));
      check("overflow",  32'(bus.o_overflow),    32'(m_ovf));
      if (q.size() != 0) begin
        check("frame", 32'(bus.o_frame),      32'(q[0].data));
        check("len",   32'(bus.o_frame_len),  32'(q[0].len));
        check("rate",  32'(bus.o_frame_rate), 32'(q[0].rate));
      end
    end
  end

  task automatic cyc();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic send(input logic [2:0] s);
    bus.i_sym       = s;
    bus.i_sym_valid = 1'b1;
    cyc();
    bus.i_sym_valid = 1'b0;
  endtask

  task automatic expect_frame(input string tag, input logic [23:0] d, input int l, input int r);
    check({tag, "_valid"}, 32'(bus.o_frame_valid), 32'd1);
    check({tag, "_frame"}, 32'(bus.o_frame),       32'(d));
    check({tag, "_len"},   32'(bus.o_frame_len),   32'(l));
    check({tag, "_rate"},  32'(bus.o_frame_rate),  32'(r));
  endtask

  initial begin
    bus.i_sym         = '0;
    bus.i_sym_valid   = 1'b0;
    bus.i_flush       = 1'b0;
    bus.i_frame_ready = 1'b0;
    repeat (3) cyc();
    check("init_len", 32'(bus.o_frame_len), 32'd0);
    check("init_ovf", 32'(bus.o_overflow),  32'd0);
    rst = 1'b1;
    cyc();

    // Rate 1/2 full frame, drained immediately
    en = 1'b1; code_rate = 2'd2; bus.i_frame_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.i_sym = 3'(i % 4); bus.i_sym_valid = 1'b1; cyc();
    end
    bus.i_sym_valid = 1'b0;
    expect_frame("r2", 24'h00E4E4, 8, 2);
    cyc();
    check("r2_one_cycle", 32'(bus.o_frame_valid), 32'd0);

    // Rate 1/3 flush; a strobe with en low must be ignored
    code_rate = 2'd3;
    en = 1'b0; send(3'd7); en = 1'b1;
    send(3'd7); send(3'd1); send(3'd5);
    bus.i_flush = 1'b1; cyc(); bus.i_flush = 1'b0;
    expect_frame("r3", 24'h00014F, 3, 3);
    cyc();
    bus.i_flush = 1'b1; cyc(); bus.i_flush = 1'b0;
    check("empty_flush", 32'(bus.o_frame_valid), 32'd0);

    // Backpressure: 20 symbols, only 16 fit
    bus.i_frame_ready = 1'b0; code_rate = 2'd2;
    for (int i = 0; i < 20; i++) begin
      bus.i_sym = (i < 8) ? 3'(i % 4) : 3'(3 - (i % 4));
      bus.i_sym_valid = 1'b1;
      cyc();
      if (i == 15) check("bp_ready_low", 32'(bus.o_sym_ready), 32'd0);
    end
    bus.i_sym_valid = 1'b0;
    check("bp_overflow", 32'(bus.o_overflow), 32'd1);
    expect_frame("bp_f0", 24'h00E4E4, 8, 2);
    bus.i_frame_ready = 1'b1; cyc();
    expect_frame("bp_f1", 24'h001B1B, 8, 2);
    check("bp_ready_back", 32'(bus.o_sym_ready), 32'd1);
    cyc();
    check("bp_drained", 32'(bus.o_frame_valid), 32'd0);

    // Frame completes in the same cycle the held frame transfers
    bus.i_frame_ready = 1'b0;
    for (int i = 0; i < 8; i++) send(3'd1);
    expect_frame("sim_a", 24'h005555, 8, 2);
    for (int i = 0; i < 7; i++) send(3'd2);
    bus.i_frame_ready = 1'b1;
    send(3'd2);
    expect_frame("sim_b", 24'h00AAAA, 8, 2);
    check("sim_ready", 32'(bus.o_sym_ready), 32'd1);
    cyc();
    check("sim_drained", 32'(bus.o_frame_valid), 32'd0);

    // Rate change mid-frame affects only the next frame
    bus.i_frame_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      code_rate = (i < 4) ? 2'd2 : 2'd3;
      send((i < 4) ? 3'(i) : (i < 8) ? 3'(4 + i % 4) : 3'd7);
    end
    expect_frame("rc_f0", 24'h00E4E4, 8, 2);
    bus.i_frame_ready = 1'b1; cyc();
    expect_frame("rc_f1", 24'hFFFFFF, 8, 3);
    cyc();
    check("rc_drained", 32'(bus.o_frame_valid), 32'd0);

    // Reset mid-frame, then a clean frame at an out-of-range rate code
    code_rate = 2'd2;
    for (int i = 0; i < 5; i++) send(3'd3);
    #2 rst = 1'b0;
    #1;
    check("mr_valid", 32'(bus.o_frame_valid), 32'd0);
    check("mr_frame", 32'(bus.o_frame),       32'd0);
    check("mr_ovf",   32'(bus.o_overflow),    32'd0);
    check("mr_ready", 32'(bus.o_sym_ready),   32'd1);
    @(posedge sys_clk); #1 rst = 1'b1;
    code_rate = 2'd1;
    for (int i = 0; i < 8; i++) send(3'((i + 1) % 4));
    expect_frame("mr_clean", 24'h003939, 8, 2);
    cyc();
    check("mr_drained", 32'(bus.o_frame_valid), 32'd0);

    repeat (2) cyc();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
